// File: rtl/stall_mem.sv
// stall_mem: multi-cycle, word-organised 16-bit data memory responder.
// Accepts one load or store at a time and completes it LATENCY edges after
// acceptance with a one-cycle rsp_done pulse. Storage is byte-addressed on
// the bus; the word index is addr[ADDR_W:1] and the upper address bits wrap.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is decoded from state only (1 in IDLE and
// RESP, 0 in WAIT), so it never depends on req_valid. The requester must hold
// its request while req_ready is 0. Request fields are captured on the
// accepting edge and are don't-care afterwards.
module stall_mem #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        req_ready,
  output logic        rsp_done,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORDS = 2 ** ADDR_W;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Request captured on the accepting edge
  logic            wr_q, wr_d;
  logic [ADDR_W:0] addr_q, addr_d;
  logic [15:0]     data_q, data_d;

  logic [15:0] mem_q [WORDS];
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic              accept;
  logic              commit;
  logic              c_wr;
  logic [ADDR_W:0]   c_addr;
  logic [15:0]       c_data;
  logic [ADDR_W-1:0] c_idx;

  // Address bits above the word index are intentionally ignored (wrap).
  logic addr_hi_unused;
  assign addr_hi_unused = ^req_addr[15:ADDR_W+1];

  assign req_ready = (state_q != WAIT);
  assign busy      = (state_q == WAIT);
  assign rsp_done  = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

  assign accept = req_valid && req_ready;

  // Next state, countdown and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          wr_d   = req_wr;
          addr_d = req_addr[ADDR_W:0];
          data_d = req_data;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The edge entering RESP is the commit edge. With LATENCY = 1 that is the
  // accepting edge itself, so the request is taken straight from the bus.
  always_comb begin
    commit = (state_d == RESP);
    if (LATENCY == 1) begin
      c_wr   = req_wr;
      c_addr = req_addr[ADDR_W:0];
      c_data = req_data;
    end else begin
      c_wr   = wr_q;
      c_addr = addr_q;
      c_data = data_q;
    end
    c_idx = c_addr[ADDR_W:1];
  end

  // Response data/error for the commit; rsp_err falls whenever not entering RESP
  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_err_d  = 1'b0;
    if (commit) begin
      if (c_addr[0]) begin
        rsp_data_d = 16'h0000;
        rsp_err_d  = 1'b1;
      end else if (c_wr) begin
        rsp_data_d = 16'h0000;
      end else begin
        rsp_data_d = mem_q[c_idx];
      end
    end
  end

  // Control and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= 16'h0000;
      rsp_data_q <= 16'h0000;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Storage: cleared by reset, written only by an aligned store commit
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= 16'h0000;
    end else if (commit && c_wr && !c_addr[0]) begin
      mem_q[c_idx] <= c_data;
    end
  end

endmodule

// File: tb/tb_stall_mem.sv
// Directed bench for stall_mem: one instance at LATENCY = 2, one at LATENCY = 1.
module tb_stall_mem;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // LATENCY = 2 instance
  logic        v = 1'b0, wr = 1'b0;
  logic [15:0] addr = 16'h0, data = 16'h0;
  logic        ready, done, err, busy;
  logic [15:0] rdata;
  logic [1:0]  st;

  // LATENCY = 1 instance
  logic        v1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr1 = 16'h0, data1 = 16'h0;
  logic        ready1, done1, err1, busy1;
  logic [15:0] rdata1;
  logic [1:0]  st1;

  int n_checks = 0;
  int n_errors = 0;

  stall_mem #(.ADDR_W(8), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_wr(wr), .req_addr(addr),
    .req_data(data), .req_ready(ready), .rsp_done(done), .rsp_data(rdata),
    .rsp_err(err), .busy(busy), .dbg_state(st)
  );

  stall_mem #(.ADDR_W(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_wr(wr1), .req_addr(addr1),
    .req_data(data1), .req_ready(ready1), .rsp_done(done1), .rsp_data(rdata1),
    .rsp_err(err1), .busy(busy1), .dbg_state(st1)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Single request on the LATENCY = 2 instance, checked cycle by cycle
  task automatic txn(input string tag, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp_data,
                     input logic exp_err);
    @(negedge clk);
    check({tag, ".ready_pre"}, ready, 1'b1);
    v = 1'b1; wr = w; addr = a; data = d;
    @(posedge clk); #1;
    v = 1'b0; wr = 1'b0; addr = 16'hFFFF; data = 16'hDEAD;
    check({tag, ".wait_busy"}, busy, 1'b1);
    check({tag, ".wait_ready"}, ready, 1'b0);
    check({tag, ".wait_done"}, done, 1'b0);
    @(posedge clk); #1;
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".data"}, rdata, exp_data);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".resp_busy"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, ".done_fall"}, done, 1'b0);
    check({tag, ".err_fall"}, err, 1'b0);
    check({tag, ".data_hold"}, rdata, exp_data);
  endtask

  // Back-to-back table: wr, addr, data, expected rsp_data
  logic        bb_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [15:0] bb_addr [4] = '{16'h0000, 16'h0002, 16'h0000, 16'h0002};
  logic [15:0] bb_data [4] = '{16'h0001, 16'h0002, 16'h0000, 16'h0000};
  logic [15:0] bb_exp  [4] = '{16'h0000, 16'h0000, 16'h0001, 16'h0002};

  // LATENCY = 1 stream table
  logic        s_wr   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] s_addr [5] = '{16'h0010, 16'h0012, 16'h0010, 16'h0012, 16'h0011};
  logic [15:0] s_data [5] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] s_exp  [5] = '{16'h0000, 16'h0000, 16'h1111, 16'h2222, 16'h0000};
  logic        s_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset for two edges with a store presented that must not be taken
    rst = 1'b0;
    v = 1'b1; wr = 1'b1; addr = 16'h0010; data = 16'hAAAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; v = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    check("rst.ready", ready, 1'b1);
    check("rst.done", done, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.data", rdata, 16'h0000);
    check("rst.state", st, 2'd0);
    check("rst.ready1", ready1, 1'b1);
    check("rst.done1", done1, 1'b0);
    txn("rst_load", 1'b0, 16'h0010, 16'h0, 16'h0000, 1'b0);

    // Store/load and address wrap
    txn("st_beef", 1'b1, 16'h0024, 16'hBEEF, 16'h0000, 1'b0);
    txn("ld_beef", 1'b0, 16'h0024, 16'h0, 16'hBEEF, 1'b0);
    txn("ld_wrap", 1'b0, 16'h0224, 16'h0, 16'hBEEF, 1'b0);

    // Misaligned store is rejected and leaves storage untouched
    txn("st_mis", 1'b1, 16'h0025, 16'h1234, 16'h0000, 1'b1);
    txn("ld_after_mis", 1'b0, 16'h0024, 16'h0, 16'hBEEF, 1'b0);
    txn("ld_mis", 1'b0, 16'h0025, 16'h0, 16'h0000, 1'b1);

    // Back-to-back with req_valid held high
    @(negedge clk);
    v = 1'b1; wr = bb_wr[0]; addr = bb_addr[0]; data = bb_data[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("bb%0d.wait_ready", i), ready, 1'b0);
      check($sformatf("bb%0d.wait_done", i), done, 1'b0);
      @(negedge clk);
      if (i < 3) begin
        wr = bb_wr[i+1]; addr = bb_addr[i+1]; data = bb_data[i+1];
      end else begin
        v = 1'b0; wr = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("bb%0d.done", i), done, 1'b1);
      check($sformatf("bb%0d.ready", i), ready, 1'b1);
      check($sformatf("bb%0d.data", i), rdata, bb_exp[i]);
    end
    @(posedge clk); #1;
    check("bb.done_fall", done, 1'b0);
    check("bb.idle", st, 2'd0);

    // LATENCY = 1 stream: done held high for every cycle of the stream
    @(negedge clk);
    v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr1 = s_wr[i]; addr1 = s_addr[i]; data1 = s_data[i];
      @(posedge clk); #1;
      check($sformatf("l1_%0d.done", i), done1, 1'b1);
      check($sformatf("l1_%0d.ready", i), ready1, 1'b1);
      check($sformatf("l1_%0d.busy", i), busy1, 1'b0);
      check($sformatf("l1_%0d.data", i), rdata1, s_exp[i]);
      check($sformatf("l1_%0d.err", i), err1, s_err[i]);
      @(negedge clk);
    end
    v1 = 1'b0; wr1 = 1'b0;
    @(posedge clk); #1;
    check("l1.done_fall", done1, 1'b0);
    check("l1.err_fall", err1, 1'b0);
    check("l1.data_hold", rdata1, 16'h0000);

    // Reset while a store is in flight
    @(negedge clk);
    v = 1'b1; wr = 1'b1; addr = 16'h0040; data = 16'hAAAA;
    @(posedge clk); #1;
    check("mid.busy", busy, 1'b1);
    v = 1'b0; wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid.done", done, 1'b0);
    check("mid.state", st, 2'd0);
    check("mid.busy_clr", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid.done_after", done, 1'b0);
    txn("mid_load", 1'b0, 16'h0040, 16'h0, 16'h0000, 1'b0);
    txn("mid_cleared", 1'b0, 16'h0024, 16'h0, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
